reg_file_rw: RTL
================

// Module: reg_file_rw
// PURPOSE
//  Parametrised single-clock register file, successor to the 2-entry 1-bit
//  read/write cell. Independent write and read ports, registered read with a
//  valid strobe, configurable write-to-read bypass, and a hardware
//  clear sequencer that initialises every entry after reset. Sits between
//  lab datapath logic and any block needing small addressable storage.
// PARAMETERS
//  WIDTH     8            data bits per entry (>=1)
//  DEPTH     4            number of entries (>=2, need not be power of 2)
//  AW        $clog2(DEPTH) address width (derived, do not override)
//  INIT_VAL  '0           value written to every entry by clear sequencer
//  BYPASS    1            1: same-cycle same-address read returns new write data
// PORTS
//  CLK       in   1      clock, all logic on posedge
//  RST       in   1      synchronous reset, active-high
//  WR_EN     in   1      write request
//  WR_ADDR   in   AW     write address
//  WR_DATA   in   WIDTH  write data
//  RD_EN     in   1      read request
//  RD_ADDR   in   AW     read address
//  RD_DATA   out  WIDTH  read data, valid when RD_VALID=1
//  RD_VALID  out  1      one-cycle strobe, read result available
//  ADDR_ERR  out  1      one-cycle strobe, previous request used addr >= DEPTH
//  BUSY      out  1      clear sequencer active; requests ignored
// BEHAVIOUR
//  - Single clock CLK; reset synchronous, active-high on RST.
//  - Reset values: RD_DATA=0, RD_VALID=0, ADDR_ERR=0, BUSY=1; FSM -> CLEAR,
//    clear pointer=0. Storage contents not reset directly.
//  - FSM CLEAR: each cycle write INIT_VAL to entry[ptr], ptr++. When
//    ptr==DEPTH-1 is written, next state READY, BUSY=0 next cycle.
//    CLEAR lasts exactly DEPTH cycles after RST deasserts.
//  - While BUSY=1: WR_EN/RD_EN ignored, no RD_VALID, no ADDR_ERR.
//  - FSM READY: stays until RST. RST asserted mid-operation (any state)
//    restarts CLEAR from ptr=0; in-flight read dropped (RD_VALID=0).
//  - Write: WR_EN=1 and WR_ADDR<DEPTH -> entry updated at that edge.
//    WR_ADDR>=DEPTH -> no entry changes, ADDR_ERR=1 next cycle.
//  - Read: RD_EN=1 at edge N -> RD_DATA/RD_VALID at edge N+1 (latency 1).
//    RD_ADDR>=DEPTH -> RD_DATA=0, RD_VALID=1, ADDR_ERR=1.
//    RD_EN=0 -> RD_VALID=0, RD_DATA holds last value.
//  - Simultaneous write+read, same valid address: BYPASS=1 returns WR_DATA;
//    BYPASS=0 returns old contents. Different addresses: fully independent.
//  - Back-to-back reads every cycle supported; RD_VALID stays high.
//  - ADDR_ERR is OR of write and read address errors in the same cycle.
// TESTING
//  1 Reset: RST=1 2 cycles, release -> BUSY=1 for exactly DEPTH(4) cycles,
//    then reads of addr 0..3 return INIT_VAL with RD_VALID one cycle later.
//  2 Write 0xA5 to addr 2, then read addr 2 -> RD_DATA=0xA5, RD_VALID=1 at
//    edge after RD_EN; addrs 0,1,3 still INIT_VAL.
//  3 Same cycle WR_EN addr1=0x3C and RD_EN addr1 (old 0x11) -> BYPASS=1:
//    RD_DATA=0x3C; BYPASS=0: RD_DATA=0x11, next read 0x3C.
//  4 DEPTH=5 (AW=3): write addr 6 -> ADDR_ERR pulse, no entry changed; read
//    addr 7 -> RD_DATA=0, RD_VALID=1, ADDR_ERR=1.
//  5 Requests during BUSY: WR_EN addr0=0xFF in clear cycle 1 -> ignored,
//    addr0 reads INIT_VAL afterward, no RD_VALID during BUSY.
//  6 RST pulse while READY with read pending -> RD_VALID=0 next cycle, BUSY=1
//    for DEPTH cycles, all entries read back INIT_VAL.

Source files
------------

// File: rtl/reg_file_rw_if.sv
// Bus bundle for reg_file_rw: write port, read port and status strobes.
// master drives requests, slave is the register file.
interface reg_file_rw_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 2
);
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             addr_err;
    logic             busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, addr_err, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, addr_err, busy
    );
endinterface

// File: rtl/reg_file_rw.sv
// Parametrised register file: independent write/read ports, registered read
// with valid strobe, optional write-to-read bypass, post-reset clear sequencer.
module reg_file_rw #(
    parameter int unsigned      WIDTH    = 8,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] INIT_VAL = '0,
    parameter bit               BYPASS   = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_rw_if.slave  bus
);
    localparam int unsigned   AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [AW-1:0]    ptr, ptr_nx;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    logic [WIDTH-1:0] rd_data_nx;
    logic             rd_valid_nx;
    logic             addr_err_nx;
    logic             busy_nx;

    logic             wr_in_range;
    logic             rd_in_range;
    logic             same_addr;

    assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_W);
    assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_W);
    assign same_addr   = (bus.wr_addr == bus.rd_addr);

    // State, clear pointer and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_CLEAR;
            ptr          <= '0;
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
            bus.addr_err <= 1'b0;
            bus.busy     <= 1'b1;
        end else begin
            state        <= state_nx;
            ptr          <= ptr_nx;
            bus.rd_data  <= rd_data_nx;
            bus.rd_valid <= rd_valid_nx;
            bus.addr_err <= addr_err_nx;
            bus.busy     <= busy_nx;
        end
    end

    // Storage is initialised by the clear sequencer rather than by reset
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Next state, storage write port and next output values
    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        mem_we      = 1'b0;
        mem_waddr   = ptr;
        mem_wdata   = INIT_VAL;
        rd_data_nx  = bus.rd_data;
        rd_valid_nx = 1'b0;
        addr_err_nx = 1'b0;
        busy_nx     = 1'b0;

        case (state)
            S_CLEAR: begin
                mem_we = 1'b1;
                if (ptr == LAST_PTR) begin
                    state_nx = S_READY;
                    ptr_nx   = '0;
                    busy_nx  = 1'b0;
                end else begin
                    ptr_nx   = ptr + AW'(1);
                    busy_nx  = 1'b1;
                end
            end

            S_READY: begin
                mem_we      = bus.wr_en && wr_in_range;
                mem_waddr   = bus.wr_addr;
                mem_wdata   = bus.wr_data;
                addr_err_nx = (bus.wr_en && !wr_in_range) ||
                              (bus.rd_en && !rd_in_range);
                if (bus.rd_en) begin
                    rd_valid_nx = 1'b1;
                    if (!rd_in_range) begin
                        rd_data_nx = '0;
                    end else if (BYPASS && bus.wr_en && same_addr) begin
                        rd_data_nx = bus.wr_data;
                    end else begin
                        rd_data_nx = mem[bus.rd_addr];
                    end
                end
            end

            default: begin
                state_nx = S_CLEAR;
                ptr_nx   = '0;
                busy_nx  = 1'b1;
            end
        endcase
    end
endmodule
